// File: rtl/alu_serial_seq_pkg.sv
// alu_serial_seq_pkg: op and state encodings shared by the serial ALU sequencer and its slice.
package alu_serial_seq_pkg;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
endpackage

// File: rtl/alu_serial_slice.sv
// alu_serial_slice: 1-bit ALU slice (AND/OR/full adder/less mux) with raw sum exposed.
module alu_serial_slice
    import alu_serial_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       less,
    input  logic       carryin,
    input  logic [1:0] op,
    output logic       result,
    output logic       carryout,
    output logic       sum
);
    logic bb;
    always_comb begin
        bb = b ^ binvert;
        sum = a ^ bb ^ carryin;
        carryout = (a & bb) | (a & carryin) | (bb & carryin);
        result = (op == OP_AND) ? (a & bb) : (op == OP_OR) ? (a | bb) : (op == OP_ADD) ? sum : less;
    end
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer, runs one slice LSB first over WIDTH cycles
// with a start/busy/done handshake.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             binvert,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_nx;
    logic [WIDTH-1:0] areg, breg, sreg, fin;
    logic [CW-1:0] count;
    logic [1:0] opr;
    logic binv, carry, cin_msb, sign, last;
    logic s_res, s_cout, s_sum;
    alu_serial_slice u_slice (
        .a(areg[0]),
        .b(breg[0]),
        .binvert(binv),
        .less(1'b0),
        .carryin(carry),
        .op(opr),
        .result(s_res),
        .carryout(s_cout),
        .sum(s_sum)
    );
    // SLT: the true sign of a-b is the MSB sum bit corrected by signed overflow
    always_comb begin
        last = count == CW'(WIDTH - 1);
        state_nx = (state == IDLE && start) ? SHIFT :
                   (state == SHIFT && last) ? FINISH :
                   (state == FINISH) ? IDLE : state;
        fin = (opr == OP_SLT) ? {{(WIDTH-1){1'b0}}, sign ^ cin_msb ^ carry} : sreg;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            areg <= '0;
            breg <= '0;
            sreg <= '0;
            count <= '0;
            opr <= OP_AND;
            binv <= 1'b0;
            carry <= 1'b0;
            cin_msb <= 1'b0;
            sign <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            carry_out <= 1'b0;
            overflow <= 1'b0;
            zero <= 1'b0;
        end else begin
            state <= state_nx;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    areg <= a;
                    breg <= b;
                    opr <= op;
                    binv <= binvert;
                    carry <= binvert;
                    count <= '0;
                    busy <= 1'b1;
                end
                SHIFT: begin
                    areg <= areg >> 1;
                    breg <= breg >> 1;
                    sreg <= {s_res, sreg[WIDTH-1:1]};
                    carry <= s_cout;
                    count <= count + 1'b1;
                    if (last) begin
                        cin_msb <= carry;
                        sign <= s_sum;
                    end
                end
                default: begin
                    result <= fin;
                    carry_out <= carry;
                    overflow <= cin_msb ^ carry;
                    zero <= fin == '0;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed and random checks of alu_serial_seq against an arithmetic model.
module tb_alu_serial_seq;
    localparam int W = 16;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, binvert = 1'b0;
    logic [1:0] op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;
    int checks = 0, failures = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .binvert(binvert),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // poke: raise start with different operands mid-flight and in the FINISH cycle
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] top,
                          input logic tbin, input bit poke, input bit chk_res);
        logic [W-1:0] bb, sum, res;
        logic [W:0] full;
        logic co, ov;
        int n;
        bit got;
        bb = tbin ? ~tb_ : tb_;
        full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, tbin};
        sum = full[W-1:0];
        co = full[W];
        ov = (ta[W-1] == bb[W-1]) && (sum[W-1] != ta[W-1]);
        res = (top == 2'b00) ? (ta & bb) : (top == 2'b01) ? (ta | bb) : (top == 2'b10) ? sum :
              (($signed(ta) < $signed(tb_)) ? W'(1) : W'(0));
        @(negedge clk);
        a = ta; b = tb_; op = top; binvert = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        got = 0;
        while (n < 40 && !got) begin
            if (poke && (n == 5 || n == 16)) begin
                start = 1'b1; op = ~top; a = ~ta; b = ta; binvert = ~tbin;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (n == 1) chk("busy_high", busy, 1);
            got = done;
        end
        chk("latency", n, 17);
        if (chk_res) begin
            chk("result", result, res);
            chk("carry_out", carry_out, co);
            chk("overflow", overflow, ov);
            chk("zero", zero, res == '0);
        end
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic no_done(input string tag, input int cyc);
        bit seen = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0] rop;
        logic rbin;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry_out, overflow, zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h7FFF, 16'h0001, 2'b10, 1'b0, 0, 1);
        run_op(16'h0005, 16'h0005, 2'b10, 1'b1, 0, 1);
        run_op(16'hFFFF, 16'h0001, 2'b10, 1'b0, 0, 1);
        run_op(16'hFFFF, 16'h0001, 2'b11, 1'b1, 0, 1);
        run_op(16'h8000, 16'h0001, 2'b11, 1'b1, 0, 1);
        run_op(16'h0003, 16'h0002, 2'b11, 1'b1, 0, 1);
        run_op(16'hF0F0, 16'h3C3C, 2'b00, 1'b0, 1, 1);
        no_done("no_queued_start", 20);
        run_op(16'hF0F0, 16'h3C3C, 2'b01, 1'b0, 0, 1);
        run_op(16'h1234, 16'h5678, 2'b11, 1'b0, 0, 0);
        // abort mid-operation with an asynchronous reset
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; op = 2'b10; binvert = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {carry_out, overflow, zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        no_done("abort_no_done", 20);
        run_op(16'h1234, 16'h1111, 2'b10, 1'b0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            ra = (i % 7 == 0) ? 16'h8000 : W'($urandom);
            rb = (i % 5 == 0) ? 16'hFFFF : W'($urandom);
            if (i % 9 == 0) rb = ra;
            rop = 2'($urandom);
            rbin = (rop == 2'b11) ? 1'b1 : 1'($urandom);
            run_op(ra, rb, rop, rbin, 0, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
Bit-serial ALU sequencer. It drives one 1-bit ALU slice over WIDTH cycles, LSB first, instead of a WIDTH-slice ripple array. It is the initiator side of the slice interface: it sources a, b, binvert, op, less and carryin, and consumes result and carryout. It is used as an area-minimal ALU for the 16-bit RISC datapath and provides a start/done handshake to the control unit.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  2  00 AND, 01 OR, 10 ADD/SUB, 11 SLT.
binvert  in  1  invert b and force initial carry-in = 1 (subtract; required for SLT).
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
busy  out  1  high while an operation is in flight.
done  out  1  one-cycle pulse; result and flags valid.
result  out  WIDTH  registered result; held until the next accepted start.
carry_out  out  1  carry out of the MSB adder stage.
overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
zero  out  1  result == 0.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; busy, done, result, carry_out, overflow, zero all 0; counter and shift registers cleared.
- States:
  - IDLE: start=1 at edge N → latch a, b, op, binvert; carry reg ← binvert; count ← 0; go to SHIFT; busy=1 from edge N.
  - SHIFT: active for exactly WIDTH edges (N+1..N+WIDTH). Each edge processes bit count:
    - slice a = areg[0]; b = breg[0]; carryin = carry reg; less = 0.
    - areg and breg shift right; slice result shifts into the MSB of the result shift reg.
    - carry reg ← carryout; count++.
  - At count==WIDTH-1:
    - capture cin_msb = carry reg.
    - capture sign = a^b'^cin at the MSB.
    - Transition to FINISH.
  - FINISH: one cycle, entered at edge N+WIDTH. Then:
    - result ← shift reg.
    - For op=11, result ← {0…, sign^overflow} (signed less-than).
    - carry_out ← carry reg; overflow ← cin_msb^carry reg.
    - zero ← (final result == 0).
    - done=1 for the single cycle after edge N+WIDTH+1.
    - busy drops with done; next state IDLE.
- Latency: done is high WIDTH+1 cycles after the start edge (17 for WIDTH=16). Minimum issue interval is WIDTH+2 cycles.
- The adder chain always runs, so carry_out and overflow are updated for every op; they are meaningful for op 10 and 11 only.
- start while busy, including the done cycle, is ignored and not queued. Operand changes after acceptance have no effect.
- Reset mid-operation aborts immediately to the reset values. No done is produced.
- op=11 with binvert=0 is illegal. The result is undefined but the block must still complete with the normal done timing.
- Width rules:
  - count is $clog2(WIDTH) bits.
  - Wrap-around: ADD 0xFFFF+0x0001 gives 0x0000, carry_out=1, overflow=0.

Decomposition:
- Shared package holds:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SLT=2'b11.
  - state encodings IDLE/SHIFT/FINISH.
- One sub-module is natural: alu_serial_slice, a 1-bit AND/OR/full-adder/less mux slice. It also exposes the raw sum bit for sign capture.
- The sequencer holds the FSM, counter, shift registers and flag logic.

Test Plan:
- ADD a=0x7FFF, b=0x0001, op=10, binvert=0 → result=0x8000, overflow=1, carry_out=0, zero=0; done exactly 17 cycles after the start edge.
- SUB a=0x0005, b=0x0005, op=10, binvert=1 → result=0x0000, zero=1, carry_out=1, overflow=0.
- SLT a=0xFFFF, b=0x0001, binvert=1 → 0x0001.
- SLT a=0x8000, b=0x0001 (overflow case) → 0x0001.
- SLT a=0x0003, b=0x0002 → 0x0000.
- AND/OR: a=0xF0F0, b=0x3C3C → op=00 gives 0x3030; op=01 gives 0xFCFC. Issue both back-to-back, with the second start asserted during busy (ignored) and then re-asserted in IDLE (accepted).
- Deassert rst_n at SHIFT cycle 8 → all outputs 0 immediately, no done. Restart with ADD 0x1234+0x1111 → 0x2345 after 17 cycles.
